// File: rtl/count_fecha_pkg.sv
// Shared encodings and constants for the calendar date counter.
// Field widths follow the output ports: day 5 bits, month 4 bits, year 7 bits.
package count_fecha_pkg;

    typedef enum logic [1:0] {
        SEL_DAY   = 2'd0,
        SEL_MONTH = 2'd1,
        SEL_YEAR  = 2'd2,
        SEL_NONE  = 2'd3
    } sel_e;

    localparam int DAY_W   = 5;
    localparam int MONTH_W = 4;
    localparam int YEAR_W  = 7;

    localparam logic [DAY_W-1:0]   DAY_RST   = 5'd1;
    localparam logic [MONTH_W-1:0] MONTH_RST = 4'd1;
    localparam logic [YEAR_W-1:0]  YEAR_RST  = 7'd0;

    localparam logic [DAY_W-1:0]   DAY_MIN   = 5'd1;
    localparam logic [MONTH_W-1:0] MONTH_MIN = 4'd1;
    localparam logic [MONTH_W-1:0] MONTH_MAX = 4'd12;
    localparam logic [YEAR_W-1:0]  YEAR_MIN  = 7'd0;

endpackage

// File: rtl/count_fecha_dias_mes.sv
// Days-in-month lookup, purely combinational; leap Februaries only when LEAP_EN=1.
// Latency 0; no backpressure.
module dias_mes
    import count_fecha_pkg::*;
#(
    parameter bit LEAP_EN = 1'b1
) (
    input  logic [MONTH_W-1:0] month_i,
    input  logic [YEAR_W-1:0]  year_i,
    output logic [DAY_W-1:0]   dim_o
);

    logic leap;
    logic year_unused;

    // Only the two low year bits matter for the divisible-by-4 rule.
    assign leap        = LEAP_EN && (year_i[1:0] == 2'b00);
    assign year_unused = ^year_i[YEAR_W-1:2];

    always_comb begin
        dim_o = 5'd31;
        case (month_i)
            4'd2:                    dim_o = leap ? 5'd29 : 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11: dim_o = 5'd30;
            default:                 dim_o = 5'd31;
        endcase
    end

endmodule

// File: rtl/count_fecha.sv
// Calendar date counter: day/month/year advanced by a daily tick, or edited field-by-field.
// Latency 1 cycle from tick/edit pulse to registered outputs; no backpressure, pulses act at once.
module count_fecha
    import count_fecha_pkg::*;
#(
    parameter int unsigned YEAR_MAX = 99,
    parameter bit          LEAP_EN  = 1'b1
) (
    input  logic               clkF,
    input  logic               resetF,
    input  logic               tickF,
    input  logic               editF,
    input  logic [1:0]         selF,
    input  logic               upF,
    input  logic               downF,
    output logic [DAY_W-1:0]   dayF,
    output logic [MONTH_W-1:0] monthF,
    output logic [YEAR_W-1:0]  yearF,
    output logic               wrapF
);

    localparam logic [YEAR_W-1:0] YEAR_TOP = YEAR_W'(YEAR_MAX);

    logic [DAY_W-1:0]   day_q,   day_d;
    logic [MONTH_W-1:0] month_q, month_d;
    logic [YEAR_W-1:0]  year_q,  year_d;
    logic               wrap_q,  wrap_d;

    logic [DAY_W-1:0]   dim_cur;
    logic [DAY_W-1:0]   dim_nxt;

    sel_e sel;
    logic run_tick;
    logic edit_inc;
    logic edit_dec;
    logic day_end;
    logic month_end;
    logic year_end;

    assign sel       = sel_e'(selF);
    assign run_tick  = !editF && tickF;
    assign edit_inc  = editF && upF && !downF;
    assign edit_dec  = editF && downF && !upF;
    assign day_end   = (day_q >= dim_cur);
    assign month_end = (month_q >= MONTH_MAX);
    assign year_end  = (year_q >= YEAR_TOP);

    // Limit of the month currently shown drives rollover and day editing.
    dias_mes #(.LEAP_EN(LEAP_EN)) u_dim_cur (
        .month_i (month_q),
        .year_i  (year_q),
        .dim_o   (dim_cur)
    );

    // Limit of the month about to be shown lets a month/year edit clamp the day in one update.
    dias_mes #(.LEAP_EN(LEAP_EN)) u_dim_nxt (
        .month_i (month_d),
        .year_i  (year_d),
        .dim_o   (dim_nxt)
    );

    always_comb begin
        year_d = year_q;
        if (run_tick) begin
            if (day_end && month_end) begin
                year_d = year_end ? YEAR_MIN : year_q + 7'd1;
            end
        end else if (sel == SEL_YEAR) begin
            if (edit_inc) begin
                year_d = year_end ? YEAR_MIN : year_q + 7'd1;
            end else if (edit_dec) begin
                year_d = (year_q == YEAR_MIN) ? YEAR_TOP : year_q - 7'd1;
            end
        end
    end

    always_comb begin
        month_d = month_q;
        if (run_tick) begin
            if (day_end) begin
                month_d = month_end ? MONTH_MIN : month_q + 4'd1;
            end
        end else if (sel == SEL_MONTH) begin
            if (edit_inc) begin
                month_d = month_end ? MONTH_MIN : month_q + 4'd1;
            end else if (edit_dec) begin
                month_d = (month_q <= MONTH_MIN) ? MONTH_MAX : month_q - 4'd1;
            end
        end
    end

    always_comb begin
        day_d = day_q;
        if (run_tick) begin
            day_d = day_end ? DAY_MIN : day_q + 5'd1;
        end else if (editF) begin
            unique case (sel)
                SEL_DAY: begin
                    if (edit_inc) begin
                        day_d = day_end ? DAY_MIN : day_q + 5'd1;
                    end else if (edit_dec) begin
                        day_d = (day_q <= DAY_MIN) ? dim_cur : day_q - 5'd1;
                    end
                end
                SEL_MONTH, SEL_YEAR: begin
                    if (day_q > dim_nxt) begin
                        day_d = dim_nxt;
                    end
                end
                SEL_NONE: day_d = day_q;
            endcase
        end
    end

    always_comb begin
        wrap_d = run_tick && day_end && month_end && year_end;
    end

    always_ff @(posedge clkF) begin
        if (resetF) begin
            day_q   <= DAY_RST;
            month_q <= MONTH_RST;
            year_q  <= YEAR_RST;
            wrap_q  <= 1'b0;
        end else begin
            day_q   <= day_d;
            month_q <= month_d;
            year_q  <= year_d;
            wrap_q  <= wrap_d;
        end
    end

    assign dayF   = day_q;
    assign monthF = month_q;
    assign yearF  = year_q;
    assign wrapF  = wrap_q;

endmodule

// File: tb/tb_count_fecha.sv
// Bench for count_fecha: a leap-enabled and a leap-disabled instance share all inputs;
// each step pushes both expected dates and the observed dates are compared per scenario.
module tb_count_fecha;

    localparam bit [1:0] S_DAY  = 2'd0;
    localparam bit [1:0] S_MON  = 2'd1;
    localparam bit [1:0] S_YR   = 2'd2;
    localparam bit [1:0] S_NONE = 2'd3;

    typedef struct packed {
        logic       w;
        logic [6:0] y;
        logic [3:0] m;
        logic [4:0] d;
    } date_t;

    typedef struct packed {
        date_t a;
        date_t b;
    } pair_t;

    logic       clk;
    logic       rst;
    logic       tick;
    logic       edit;
    logic [1:0] sel;
    logic       up;
    logic       down;

    logic [4:0] a_day,   b_day;
    logic [3:0] a_month, b_month;
    logic [6:0] a_year,  b_year;
    logic       a_wrap,  b_wrap;

    pair_t exp_q[$];
    pair_t obs_q[$];
    int    tests = 0;
    int    fails = 0;

    count_fecha #(.YEAR_MAX(99), .LEAP_EN(1'b1)) u_a (
        .clkF   (clk),
        .resetF (rst),
        .tickF  (tick),
        .editF  (edit),
        .selF   (sel),
        .upF    (up),
        .downF  (down),
        .dayF   (a_day),
        .monthF (a_month),
        .yearF  (a_year),
        .wrapF  (a_wrap)
    );

    count_fecha #(.YEAR_MAX(99), .LEAP_EN(1'b0)) u_b (
        .clkF   (clk),
        .resetF (rst),
        .tickF  (tick),
        .editF  (edit),
        .selF   (sel),
        .upF    (up),
        .downF  (down),
        .dayF   (b_day),
        .monthF (b_month),
        .yearF  (b_year),
        .wrapF  (b_wrap)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic date_t D(input int d, input int m, input int y, input bit w = 1'b0);
        date_t r;
        r.d = d[4:0];
        r.m = m[3:0];
        r.y = y[6:0];
        r.w = w;
        return r;
    endfunction

    // One clock of stimulus: expectation queued now, outputs captured #1 after the edge.
    task automatic drive(input bit r, input bit t, input bit e, input bit [1:0] s,
                         input bit u, input bit d, input date_t ea, input date_t eb);
        pair_t p;
        rst  = r;
        tick = t;
        edit = e;
        sel  = s;
        up   = u;
        down = d;
        p.a = ea;
        p.b = eb;
        exp_q.push_back(p);
        @(posedge clk);
        #1;
        p.a = {a_wrap, a_year, a_month, a_day};
        p.b = {b_wrap, b_year, b_month, b_day};
        obs_q.push_back(p);
        rst  = 1'b0;
        tick = 1'b0;
        up   = 1'b0;
        down = 1'b0;
    endtask

    task automatic drive1(input bit r, input bit t, input bit e, input bit [1:0] s,
                          input bit u, input bit d, input date_t ex);
        drive(r, t, e, s, u, d, ex, ex);
    endtask

    task automatic test_reset();
        pair_t e, o;
        int    step = 0;
        drive1(1, 1, 1, S_DAY, 1, 0, D(1, 1, 0));
        drive1(1, 1, 0, S_NONE, 0, 1, D(1, 1, 0));
        drive1(0, 0, 0, S_NONE, 0, 0, D(1, 1, 0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            tests++;
            step++;
            if (o !== e) begin
                fails++;
                $display("FAIL reset step %0d: got a=%h b=%h, expected a=%h b=%h", step, o.a, o.b, e.a, e.b);
            end
        end
    endtask

    task automatic test_run_month();
        pair_t e, o;
        int    step = 0;
        drive1(1, 0, 0, S_NONE, 0, 0, D(1, 1, 0));
        for (int k = 1; k <= 31; k++) begin
            drive1(0, 1, 0, S_NONE, 0, 0, (k < 31) ? D(k + 1, 1, 0) : D(1, 2, 0));
        end
        // Edit controls without editF must be ignored, with and without a tick.
        drive1(0, 0, 0, S_DAY, 1, 0, D(1, 2, 0));
        drive1(0, 1, 0, S_MON, 0, 1, D(2, 2, 0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            tests++;
            step++;
            if (o !== e) begin
                fails++;
                $display("FAIL run_month step %0d: got a=%h b=%h, expected a=%h b=%h", step, o.a, o.b, e.a, e.b);
            end
        end
    endtask

    task automatic test_leap();
        pair_t e, o;
        int    step = 0;
        // 28 Feb year 3 -> 1 Mar on both instances.
        drive1(1, 0, 0, S_NONE, 0, 0, D(1, 1, 0));
        for (int y = 1; y <= 3; y++) drive1(0, 0, 1, S_YR, 1, 0, D(1, 1, y));
        drive1(0, 0, 1, S_MON, 1, 0, D(1, 2, 3));
        drive1(0, 0, 1, S_DAY, 0, 1, D(28, 2, 3));
        drive1(0, 1, 0, S_NONE, 0, 0, D(1, 3, 3));
        // Year 4: leap instance sees 29 Feb, the other 28 Feb.
        drive1(1, 0, 0, S_NONE, 0, 0, D(1, 1, 0));
        for (int y = 1; y <= 4; y++) drive1(0, 0, 1, S_YR, 1, 0, D(1, 1, y));
        drive1(0, 0, 1, S_MON, 1, 0, D(1, 2, 4));
        drive(0, 0, 1, S_DAY, 0, 1, D(29, 2, 4), D(28, 2, 4));
        drive1(0, 1, 0, S_NONE, 0, 0, D(1, 3, 4));
        drive1(1, 0, 0, S_NONE, 0, 0, D(1, 1, 0));
        for (int y = 1; y <= 4; y++) drive1(0, 0, 1, S_YR, 1, 0, D(1, 1, y));
        drive1(0, 0, 1, S_MON, 1, 0, D(1, 2, 4));
        drive(0, 0, 1, S_DAY, 0, 1, D(29, 2, 4), D(28, 2, 4));
        drive(0, 0, 1, S_DAY, 0, 1, D(28, 2, 4), D(27, 2, 4));
        drive(0, 1, 0, S_NONE, 0, 0, D(29, 2, 4), D(28, 2, 4));
        drive1(0, 1, 0, S_NONE, 0, 0, D(1, 3, 4));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            tests++;
            step++;
            if (o !== e) begin
                fails++;
                $display("FAIL leap step %0d: got a=%h b=%h, expected a=%h b=%h", step, o.a, o.b, e.a, e.b);
            end
        end
    endtask

    task automatic test_year_wrap();
        pair_t e, o;
        int    step = 0;
        drive1(1, 0, 0, S_NONE, 0, 0, D(1, 1, 0));
        drive1(0, 0, 1, S_YR, 0, 1, D(1, 1, 99));
        drive1(0, 0, 1, S_MON, 0, 1, D(1, 12, 99));
        drive1(0, 0, 1, S_DAY, 0, 1, D(31, 12, 99));
        drive1(0, 1, 0, S_NONE, 0, 0, D(1, 1, 0, 1'b1));
        drive1(0, 0, 0, S_NONE, 0, 0, D(1, 1, 0));
        drive1(0, 1, 0, S_NONE, 0, 0, D(2, 1, 0));
        // Year edits wrap the field but never raise wrapF.
        drive1(0, 0, 1, S_YR, 0, 1, D(2, 1, 99));
        drive1(0, 0, 1, S_YR, 1, 0, D(2, 1, 0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            tests++;
            step++;
            if (o !== e) begin
                fails++;
                $display("FAIL year_wrap step %0d: got a=%h b=%h, expected a=%h b=%h", step, o.a, o.b, e.a, e.b);
            end
        end
    endtask

    task automatic test_edit_clamp();
        pair_t e, o;
        int    step = 0;
        drive1(1, 0, 0, S_NONE, 0, 0, D(1, 1, 0));
        drive1(0, 0, 1, S_DAY, 0, 1, D(31, 1, 0));
        drive(0, 0, 1, S_MON, 1, 0, D(29, 2, 0), D(28, 2, 0));
        drive1(0, 0, 1, S_YR, 1, 0, D(28, 2, 1));
        drive1(0, 0, 1, S_DAY, 1, 0, D(1, 2, 1));
        drive1(0, 0, 1, S_MON, 0, 1, D(1, 1, 1));
        drive1(0, 0, 1, S_MON, 0, 1, D(1, 12, 1));
        drive1(0, 0, 1, S_MON, 1, 0, D(1, 1, 1));
        drive1(0, 0, 1, S_DAY, 0, 1, D(31, 1, 1));
        drive1(0, 0, 1, S_DAY, 1, 0, D(1, 1, 1));
        drive1(0, 0, 1, S_DAY, 0, 1, D(31, 1, 1));
        drive1(0, 0, 1, S_MON, 1, 0, D(28, 2, 1));
        drive1(0, 0, 1, S_MON, 0, 1, D(28, 1, 1));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            tests++;
            step++;
            if (o !== e) begin
                fails++;
                $display("FAIL edit_clamp step %0d: got a=%h b=%h, expected a=%h b=%h", step, o.a, o.b, e.a, e.b);
            end
        end
    endtask

    task automatic test_edit_ignore();
        pair_t e, o;
        int    step = 0;
        drive1(1, 0, 0, S_NONE, 0, 0, D(1, 1, 0));
        drive1(0, 0, 1, S_DAY, 0, 1, D(31, 1, 0));
        drive1(0, 0, 1, S_DAY, 1, 1, D(31, 1, 0));
        drive1(0, 0, 1, S_MON, 1, 1, D(31, 1, 0));
        drive1(0, 1, 1, S_NONE, 0, 0, D(31, 1, 0));
        drive1(0, 1, 1, S_NONE, 0, 0, D(31, 1, 0));
        drive1(0, 0, 1, S_NONE, 1, 0, D(31, 1, 0));
        drive1(0, 0, 1, S_NONE, 0, 1, D(31, 1, 0));
        drive1(0, 0, 0, S_NONE, 0, 0, D(31, 1, 0));
        drive1(0, 1, 0, S_NONE, 0, 0, D(1, 2, 0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            tests++;
            step++;
            if (o !== e) begin
                fails++;
                $display("FAIL edit_ignore step %0d: got a=%h b=%h, expected a=%h b=%h", step, o.a, o.b, e.a, e.b);
            end
        end
    endtask

    task automatic test_reset_priority();
        pair_t e, o;
        int    step = 0;
        drive1(1, 0, 0, S_NONE, 0, 0, D(1, 1, 0));
        drive1(0, 0, 1, S_YR, 0, 1, D(1, 1, 99));
        drive1(0, 0, 1, S_MON, 0, 1, D(1, 12, 99));
        drive1(0, 0, 1, S_DAY, 0, 1, D(31, 12, 99));
        drive1(1, 1, 0, S_NONE, 0, 0, D(1, 1, 0));
        drive1(0, 0, 0, S_NONE, 0, 0, D(1, 1, 0));
        drive1(0, 0, 1, S_DAY, 0, 1, D(31, 1, 0));
        drive1(1, 0, 1, S_DAY, 1, 0, D(1, 1, 0));
        drive1(0, 0, 0, S_NONE, 0, 0, D(1, 1, 0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            tests++;
            step++;
            if (o !== e) begin
                fails++;
                $display("FAIL reset_priority step %0d: got a=%h b=%h, expected a=%h b=%h", step, o.a, o.b, e.a, e.b);
            end
        end
    endtask

    initial begin
        rst  = 1'b1;
        tick = 1'b0;
        edit = 1'b0;
        sel  = S_NONE;
        up   = 1'b0;
        down = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_run_month();
        test_leap();
        test_year_wrap();
        test_edit_clamp();
        test_edit_ignore();
        test_reset_priority();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/count_fecha.md
COUNT_FECHA -- requirements
Module: count_fecha

Interface
REQ-001 Parameter YEAR_MAX, default 99: highest year value before the year wraps to 0.
REQ-002 Parameter LEAP_EN, default 1: when 1, February of years divisible by 4 has 29 days; when 0, February always has 28 days.
REQ-003 The clock and reset are already decided and SHALL be: one clock; reset is synchronous and active-high.
REQ-004 clkF  input  1  single clock; all state updates on its rising edge.
REQ-005 resetF  input  1  synchronous, active-high reset.
REQ-006 tickF  input  1  one-cycle day-advance pulse from the time-of-day chain.
REQ-007 editF  input  1  1 = manual adjust mode; 0 = run mode.
REQ-008 selF  input  2  field select: 0 = day, 1 = month, 2 = year, 3 = none.
REQ-009 upF  input  1  one-cycle increment request for the selected field.
REQ-010 downF  input  1  one-cycle decrement request for the selected field.
REQ-011 dayF  output  5  current day, range 1..days_in_month.
REQ-012 monthF  output  4  current month, range 1..12.
REQ-013 yearF  output  7  current year, range 0..YEAR_MAX.
REQ-014 wrapF  output  1  one-cycle pulse when the year wraps from YEAR_MAX to 0 in run mode.

Function
REQ-015 days_in_month SHALL be 31 for months 1,3,5,7,8,10,12; 30 for months 4,6,9,11; 28 for February; 29 for February when LEAP_EN=1 and yearF[1:0]==0.
REQ-016 Run mode, editF=0 and tickF=1: day SHALL increment by 1, with the result visible 1 cycle after the tick edge.
REQ-017 Run mode, tickF=1 and day==days_in_month: day SHALL become 1 and month SHALL increment, in the same cycle.
REQ-018 Run mode, tickF=1, day at limit and month==12: month SHALL become 1 and year SHALL increment.
REQ-019 Run mode, tickF=1, day at limit, month==12 and year==YEAR_MAX: year SHALL become 0 and wrapF SHALL be 1 for exactly that cycle.
REQ-020 Run mode: upF, downF and selF SHALL be ignored.
REQ-021 Edit mode, editF=1: tickF SHALL be ignored, so ticks that arrive during editing are lost; wrapF SHALL stay 0.
REQ-022 Edit mode, upF=1 and downF=0: the selected field SHALL increment, wrapping from its maximum to its minimum.
  - day: max is days_in_month, min is 1.
  - month: max is 12, min is 1.
  - year: max is YEAR_MAX, min is 0.
  - Other fields SHALL NOT change.
REQ-023 Edit mode, downF=1 and upF=0: the selected field SHALL decrement, wrapping from its minimum to its maximum.
REQ-024 Edit mode with upF=downF=1, or with selF=3: no field SHALL change.
REQ-025 After a month or year edit, if day exceeds the new days_in_month, day SHALL be clamped to the new days_in_month in the same update.
REQ-026 Every field update SHALL take 1 cycle; outputs SHALL come directly from registers with no combinational path from inputs.
REQ-027 All arithmetic SHALL stay within the field width; no intermediate value outside a field's legal range SHALL ever appear on an output.

Reset
REQ-028 With resetF=1 at a clock edge, the next state SHALL be dayF=1, monthF=1, yearF=0, wrapF=0, regardless of all other inputs.
REQ-029 Reset SHALL take priority over any tick or edit in the same cycle, including reset asserted mid-edit or mid-rollover.

Structure
REQ-030 A shared package count_fecha_pkg SHALL hold:
  - field-select encodings SEL_DAY, SEL_MONTH, SEL_YEAR, SEL_NONE;
  - reset constants DAY_RST, MONTH_RST, YEAR_RST.
REQ-031 The days_in_month lookup SHALL be one combinational sub-module, dias_mes, with inputs month and year and LEAP_EN as its parameter.
REQ-032 The next-state logic SHALL live in one combinational block per field, with a single register bank.

Verification
REQ-033 Reset, then 31 ticks -> 1 Feb, year 0 (day=1, month=2).
REQ-034 Set 28 Feb, year 3, tick -> 1 Mar; set 28 Feb, year 4, tick -> 29 Feb, tick -> 1 Mar; repeat with LEAP_EN=0 and year 4: 28 Feb -> 1 Mar.
REQ-035 Set 31 Dec, YEAR_MAX, tick -> 1 Jan, year 0, with wrapF high for exactly 1 cycle.
REQ-036 Edit mode, set 31 Jan, select month, upF -> month=2 and day clamped to 28 (29 if year%4==0); downF on month=1 -> month=12.
REQ-037 Edit mode: upF with downF together -> no change; tickF pulses -> no change; selF=3 with upF -> no change.
REQ-038 resetF asserted in the same cycle as a year-wrapping tick -> 1 Jan, year 0, wrapF=0.
